wb_lsu_master: RTL and testbench

- Wishbone bus master that sits directly upstream of the ram slave.
- Converts core load/store requests (byte/half/word, signed/unsigned) into single Wishbone classic cycles: word address, lane select mask and replicated write data.
- Extracts and extends load data from the returned word.
- Reports misalignment, slave error and ack timeout back to the core.

---
 rtl/lsu_pkg.sv | 28 ++
 rtl/wishbone_if.sv | 24 ++
 rtl/wb_lane_align.sv | 55 +++++
 rtl/wb_lsu_master.sv | 155 +++++++++++++++
 tb/tb_wb_lsu_master.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit Wishbone master: access size,
// response error code and FSM state.
package lsu_pkg;

    // Request access size; 2'b11 is reserved and always reported as misaligned.
    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    // Completion status returned to the core.
    typedef enum logic [1:0] {
        ERR_NONE     = 2'b00,
        ERR_MISALIGN = 2'b01,
        ERR_BUS      = 2'b10,
        ERR_TIMEOUT  = 2'b11
    } err_e;

    // Master FSM: wait for a request, run one classic cycle, pulse the response.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUS  = 2'b01,
        ST_RESP = 2'b10
    } state_e;

endpackage

// File: rtl/wishbone_if.sv
// Single-master Wishbone classic bundle with a fixed 32-bit data path.
interface wishbone_if #(
    parameter int ADDR_W = 32
);
    logic              cyc;
    logic              stb;
    logic              we;
    logic [ADDR_W-1:0] adr;
    logic [3:0]        sel;
    logic [31:0]       dat_m2s;
    logic [31:0]       dat_s2m;
    logic              ack;
    logic              err;

    modport master (
        output cyc, stb, we, adr, sel, dat_m2s,
        input  dat_s2m, ack, err
    );

    modport slave (
        input  cyc, stb, we, adr, sel, dat_m2s,
        output dat_s2m, ack, err
    );
endinterface

// File: rtl/wb_lane_align.sv
// Byte-lane steering for stores and lane extraction/extension for loads.
// Purely combinational; also flags accesses that straddle their natural size.
module wb_lane_align
    import lsu_pkg::*;
(
    input  size_e       size,
    input  logic [1:0]  addr_lo,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    input  logic [31:0] dat_s2m,
    output logic [3:0]  sel,
    output logic [31:0] dat_m2s,
    output logic [31:0] rdata,
    output logic        misaligned
);

    logic [31:0] shifted;

    assign shifted = dat_s2m >> {addr_lo, 3'b000};

    // Lane select, replicated store data, alignment check and load extension.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        sel        = 4'b0000;
        dat_m2s    = 32'h0;
        rdata      = 32'h0;
        misaligned = 1'b1;
        case (size)
            SZ_BYTE: begin
                sel        = 4'b0001 << addr_lo;
                dat_m2s    = {4{wdata[7:0]}};
                misaligned = 1'b0;
                rdata      = is_unsigned ? {24'h0, shifted[7:0]}
                                         : {{24{shifted[7]}}, shifted[7:0]};
            end
            SZ_HALF: begin
                sel        = addr_lo[1] ? 4'b1100 : 4'b0011;
                dat_m2s    = {2{wdata[15:0]}};
                misaligned = addr_lo[0];
                rdata      = is_unsigned ? {16'h0, shifted[15:0]}
                                         : {{16{shifted[15]}}, shifted[15:0]};
            end
            SZ_WORD: begin
                sel        = 4'b1111;
                dat_m2s    = wdata;
                misaligned = |addr_lo;
                rdata      = dat_s2m;
            end
            default: begin
                misaligned = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/wb_lsu_master.sv
// Load/store unit Wishbone classic master: one outstanding single-beat
// transfer per core request, with misalignment, bus error and ack timeout
// reported on a one-cycle response pulse.
module wb_lsu_master
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int ADDR_W         = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic [1:0]        resp_err,
    wishbone_if.master        wishbone
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

    state_e             state, state_next;
    logic               ready_en;
    size_e              r_size;
    logic [1:0]         r_addr_lo;
    logic               r_unsigned;
    logic [CNT_W-1:0]   tmo_cnt;
    err_e               resp_err_q;

    logic               accept;
    logic               tmo_hit;
    logic               bus_done;

    size_e              al_size;
    logic [1:0]         al_addr_lo;
    logic               al_unsigned;
    logic [3:0]         al_sel;
    logic [31:0]        al_dat_m2s;
    logic [31:0]        al_rdata;
    logic               al_misaligned;

    // ready_en keeps req_ready low until the first clock after reset release.
    assign req_ready  = ready_en && (state == ST_IDLE);
    assign accept     = req_valid && req_ready;
    assign tmo_hit    = (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign bus_done   = wishbone.err || wishbone.ack || tmo_hit;
    assign resp_valid = (state == ST_RESP);
    assign resp_err   = resp_err_q;

    // The aligner sees the live request while idle (steering and alignment
    // check) and the registered request afterwards (load extraction).
    assign al_size     = (state == ST_IDLE) ? size_e'(req_size) : r_size;
    assign al_addr_lo  = (state == ST_IDLE) ? req_addr[1:0]     : r_addr_lo;
    assign al_unsigned = (state == ST_IDLE) ? req_unsigned      : r_unsigned;

    wb_lane_align u_align (
        .size        (al_size),
        .addr_lo     (al_addr_lo),
        .is_unsigned (al_unsigned),
        .wdata       (req_wdata),
        .dat_s2m     (wishbone.dat_s2m),
        .sel         (al_sel),
        .dat_m2s     (al_dat_m2s),
        .rdata       (al_rdata),
        .misaligned  (al_misaligned)
    );

    // FSM state register; async reset abandons any in-flight transfer.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!reset) state <= ST_IDLE;
        else        state <= state_next;
    end

    // Next-state decode.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (accept)   state_next = al_misaligned ? ST_RESP : ST_BUS;
            ST_BUS:  if (bus_done) state_next = ST_RESP;
            ST_RESP:               state_next = ST_IDLE;
            default:               state_next = ST_IDLE;
        endcase
    end

    // Request capture, bus signal drive, timeout counting and response capture.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ready_en         <= 1'b0;
            r_size           <= SZ_BYTE;
            r_addr_lo        <= 2'b00;
            r_unsigned       <= 1'b0;
            tmo_cnt          <= '0;
            resp_rdata       <= 32'h0;
            resp_err_q       <= ERR_NONE;
            wishbone.cyc     <= 1'b0;
            wishbone.stb     <= 1'b0;
            wishbone.we      <= 1'b0;
            wishbone.adr     <= '0;
            wishbone.sel     <= 4'b0000;
            wishbone.dat_m2s <= 32'h0;
        end else begin
            ready_en <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        r_size     <= size_e'(req_size);
                        r_addr_lo  <= req_addr[1:0];
                        r_unsigned <= req_unsigned;
                        tmo_cnt    <= '0;
                        if (al_misaligned) begin
                            resp_rdata <= 32'h0;
                            resp_err_q <= ERR_MISALIGN;
                        end else begin
                            wishbone.cyc     <= 1'b1;
                            wishbone.stb     <= 1'b1;
                            wishbone.we      <= req_we;
                            wishbone.adr     <= {req_addr[ADDR_W-1:2], 2'b00};
                            wishbone.sel     <= al_sel;
                            wishbone.dat_m2s <= req_we ? al_dat_m2s : 32'h0;
                        end
                    end
                end
                ST_BUS: begin
                    if (bus_done) begin
                        // err beats ack, ack beats a same-cycle timeout.
                        if (wishbone.err) begin
                            resp_err_q <= ERR_BUS;
                            resp_rdata <= 32'h0;
                        end else if (wishbone.ack) begin
                            resp_err_q <= ERR_NONE;
                            resp_rdata <= wishbone.we ? 32'h0 : al_rdata;
                        end else begin
                            resp_err_q <= ERR_TIMEOUT;
                            resp_rdata <= 32'h0;
                        end
                        wishbone.cyc <= 1'b0;
                        wishbone.stb <= 1'b0;
                        wishbone.we  <= 1'b0;
                        wishbone.sel <= 4'b0000;
                    end else if (tmo_cnt != '1) begin
                        tmo_cnt <= tmo_cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_lsu_master.sv
// Directed bench for wb_lsu_master against a small behavioural RAM slave
// whose ack/err behaviour is selected by slv_mode.
module tb_wb_lsu_master;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic [1:0]  resp_err;

    int checks = 0;
    int errors = 0;

    // 0 zero-wait ack, 1 never respond, 2 ack+err together, 3 ack on 8th stb cycle
    int          slv_mode = 0;
    int          stb_cnt  = 0;
    logic [31:0] mem [16];

    wishbone_if #(.ADDR_W(32)) wb_bus ();

    wb_lsu_master #(.TIMEOUT_CYCLES(8), .ADDR_W(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .wishbone     (wb_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural slave
    assign wb_bus.dat_s2m = mem[wb_bus.adr[5:2]];
    assign wb_bus.err     = (slv_mode == 2) && wb_bus.cyc && wb_bus.stb;
    assign wb_bus.ack     = wb_bus.cyc && wb_bus.stb &&
                            ((slv_mode == 0) || (slv_mode == 2) ||
                             ((slv_mode == 3) && (stb_cnt == 7)));

    always @(posedge clk) begin
        if (wb_bus.stb) stb_cnt <= stb_cnt + 1;
        else            stb_cnt <= 0;
        if (wb_bus.cyc && wb_bus.stb && wb_bus.we && wb_bus.ack && !wb_bus.err) begin
            for (int b = 0; b < 4; b++)
                if (wb_bus.sel[b]) mem[wb_bus.adr[5:2]][8*b +: 8] <= wb_bus.dat_m2s[8*b +: 8];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One request from an idle master; returns what was observed on the bus
    // and the response. lat counts cycles after the acceptance edge.
    task automatic xact(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic [1:0] err,
                        output int lat, output logic [3:0] sel_seen,
                        output logic [31:0] dat_seen, output int stb_cycles,
                        output logic cyc_seen);
        logic done;
        rdata = 0; err = 0; lat = 0; sel_seen = 0; dat_seen = 0;
        stb_cycles = 0; cyc_seen = 0; done = 0;
        @(negedge clk);
        check("ready_before_req", {31'h0, req_ready}, 32'h1);
        req_valid = 1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        @(posedge clk);
        @(negedge clk);
        req_valid = 0;
        for (int i = 1; i <= 40; i++) begin
            lat = i;
            if (wb_bus.cyc) begin
                cyc_seen = 1;
                sel_seen = wb_bus.sel;
                dat_seen = wb_bus.dat_m2s;
            end
            if (wb_bus.stb) stb_cycles++;
            if (resp_valid) begin
                rdata = resp_rdata;
                err   = resp_err;
                done  = 1;
                break;
            end
            @(negedge clk);
        end
        if (!done) check("resp_bound", 32'h0, 32'h1);
    endtask

    logic [31:0] rd, dat;
    logic [1:0]  er;
    logic [3:0]  sl;
    logic        cs;
    int          lat, nstb;
    logic        rv_seen;

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        reset = 0; req_valid = 0; req_we = 0; req_size = 0; req_unsigned = 0;
        req_addr = 0; req_wdata = 0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_ready", {31'h0, req_ready}, 32'h0);
        check("rst_cyc_stb", {30'h0, wb_bus.cyc, wb_bus.stb}, 32'h0);
        check("rst_sel_adr", {wb_bus.sel, wb_bus.adr[27:0]}, 32'h0);
        check("rst_resp", {29'h0, resp_valid, resp_err}, 32'h0);
        check("rst_rdata", resp_rdata, 32'h0);
        reset = 1;
        @(negedge clk);
        check("ready_after_rel", {31'h0, req_ready}, 32'h1);

        // Word store then word load
        xact(1, 2'b10, 0, 32'h0, 32'hA000_1234, rd, er, lat, sl, dat, nstb, cs);
        check("wst_sel", {28'h0, sl}, 32'hF);
        check("wst_dat", dat, 32'hA000_1234);
        check("wst_err", {30'h0, er}, 32'h0);
        check("wst_lat", lat, 2);
        xact(0, 2'b10, 0, 32'h0, 32'h0, rd, er, lat, sl, dat, nstb, cs);
        check("wld_sel", {28'h0, sl}, 32'hF);
        check("wld_rdata", rd, 32'hA000_1234);
        check("wld_err", {30'h0, er}, 32'h0);
        check("wld_lat", lat, 2);
        check("wld_ready_in_resp", {31'h0, req_ready}, 32'h0);
        @(negedge clk);
        check("wld_ready_n3", {31'h0, req_ready}, 32'h1);

        // Half store and half loads
        xact(1, 2'b01, 0, 32'h2, 32'h0000_CAFE, rd, er, lat, sl, dat, nstb, cs);
        check("hst_dat", dat, 32'hCAFE_CAFE);
        check("hst_sel", {28'h0, sl}, 32'hC);
        xact(0, 2'b10, 0, 32'h0, 32'h0, rd, er, lat, sl, dat, nstb, cs);
        check("hst_word_back", rd, 32'hCAFE_1234);
        xact(0, 2'b01, 0, 32'h2, 32'h0, rd, er, lat, sl, dat, nstb, cs);
        check("hld_signed", rd, 32'hFFFF_CAFE);
        check("hld_sel", {28'h0, sl}, 32'hC);
        xact(0, 2'b01, 1, 32'h2, 32'h0, rd, er, lat, sl, dat, nstb, cs);
        check("hld_unsigned", rd, 32'h0000_CAFE);

        // Byte loads from 0xDEAD80EF at word 0x4
        xact(1, 2'b10, 0, 32'h4, 32'hDEAD_80EF, rd, er, lat, sl, dat, nstb, cs);
        xact(0, 2'b00, 0, 32'h5, 32'h0, rd, er, lat, sl, dat, nstb, cs);
        check("bld_signed", rd, 32'hFFFF_FF80);
        check("bld_sel", {28'h0, sl}, 32'h2);
        xact(0, 2'b00, 1, 32'h5, 32'h0, rd, er, lat, sl, dat, nstb, cs);
        check("bld_unsigned", rd, 32'h0000_0080);
        xact(0, 2'b00, 1, 32'h7, 32'h0, rd, er, lat, sl, dat, nstb, cs);
        check("bld_lane3", rd, 32'h0000_00DE);

        // Byte store 0x55 at 0x3
        xact(1, 2'b00, 0, 32'h3, 32'h0000_0055, rd, er, lat, sl, dat, nstb, cs);
        check("bst_sel", {28'h0, sl}, 32'h8);
        check("bst_dat", dat, 32'h5555_5555);
        check("bst_rdata", rd, 32'h0);
        xact(0, 2'b10, 0, 32'h0, 32'h0, rd, er, lat, sl, dat, nstb, cs);
        check("bst_word_back", rd, 32'h55FE_1234);

        // Misaligned requests never touch the bus
        xact(0, 2'b10, 0, 32'h2, 32'h0, rd, er, lat, sl, dat, nstb, cs);
        check("mis_wld_cyc", {31'h0, cs}, 32'h0);
        check("mis_wld_err", {30'h0, er}, 32'h1);
        check("mis_wld_rdata", rd, 32'h0);
        check("mis_wld_lat", lat, 1);
        xact(1, 2'b01, 0, 32'h1, 32'hFFFF_FFFF, rd, er, lat, sl, dat, nstb, cs);
        check("mis_hst_cyc", {31'h0, cs}, 32'h0);
        check("mis_hst_err", {30'h0, er}, 32'h1);
        xact(0, 2'b11, 0, 32'h0, 32'h0, rd, er, lat, sl, dat, nstb, cs);
        check("mis_sz3_cyc", {31'h0, cs}, 32'h0);
        check("mis_sz3_err", {30'h0, er}, 32'h1);
        check("mis_sz3_lat", lat, 1);

        // Timeout, bus error, ack on the last timeout cycle
        slv_mode = 1;
        xact(0, 2'b10, 0, 32'h0, 32'h0, rd, er, lat, sl, dat, nstb, cs);
        check("tmo_stb_cycles", nstb, 8);
        check("tmo_err", {30'h0, er}, 32'h3);
        check("tmo_rdata", rd, 32'h0);
        slv_mode = 2;
        xact(0, 2'b10, 0, 32'h0, 32'h0, rd, er, lat, sl, dat, nstb, cs);
        check("ackerr_err", {30'h0, er}, 32'h2);
        check("ackerr_rdata", rd, 32'h0);
        slv_mode = 3;
        xact(0, 2'b10, 0, 32'h0, 32'h0, rd, er, lat, sl, dat, nstb, cs);
        check("lastack_err", {30'h0, er}, 32'h0);
        check("lastack_rdata", rd, 32'h55FE_1234);
        check("lastack_stb_cycles", nstb, 8);

        // Reset two cycles into a stalled load
        slv_mode = 1;
        @(negedge clk);
        req_valid = 1; req_we = 0; req_size = 2'b10; req_unsigned = 0; req_addr = 32'h0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 0;
        check("stall_stb", {31'h0, wb_bus.stb}, 32'h1);
        @(negedge clk);
        #2 reset = 0;
        #1;
        check("async_drop", {30'h0, wb_bus.cyc, wb_bus.stb}, 32'h0);
        rv_seen = 0;
        repeat (2) begin
            @(negedge clk);
            rv_seen = rv_seen | resp_valid;
        end
        check("rst_ready_low", {31'h0, req_ready}, 32'h0);
        reset = 1;
        repeat (2) begin
            @(negedge clk);
            rv_seen = rv_seen | resp_valid;
        end
        check("no_resp_after_rst", {31'h0, rv_seen}, 32'h0);
        check("ready_after_rst", {31'h0, req_ready}, 32'h1);
        slv_mode = 0;
        xact(0, 2'b10, 0, 32'h0, 32'h0, rd, er, lat, sl, dat, nstb, cs);
        check("post_rst_rdata", rd, 32'h55FE_1234);
        check("post_rst_err", {30'h0, er}, 32'h0);

        // Late ack while idle must not produce a response
        slv_mode = 2;
        rv_seen = 0;
        repeat (3) begin
            @(negedge clk);
            rv_seen = rv_seen | resp_valid;
        end
        check("idle_no_resp", {31'h0, rv_seen}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
